// File: rtl/cmac_pkg.sv
// Shared definitions for the sequential complex MAC: FSM encoding, the result
// width helper and the indices of the real/imag fields in packed operands.
package cmac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_M0   = 3'd1,
    ST_M1   = 3'd2,
    ST_M2   = 3'd3,
    ST_M3   = 3'd4,
    ST_DONE = 3'd5
  } cmac_state_e;

  // Operands and results are viewed as [1:0][W-1:0]; element 1 is real, 0 is imag.
  localparam int FLD_RE = 1;
  localparam int FLD_IM = 0;

  function automatic int ow_width(input int cw, input int guard);
    return 2 * cw + guard;
  endfunction

endpackage

// File: rtl/cmac_smul.sv
// Combinational signed CW x CW -> 2CW multiplier shared by all compute states.
module cmac_smul #(
  parameter int CW = 8
) (
  input  logic signed [CW-1:0]   i_a,
  input  logic signed [CW-1:0]   i_b,
  output logic signed [2*CW-1:0] o_p
);

  assign o_p = i_a * i_b;

endmodule

// File: rtl/cmac_seq.sv
// Sequential complex multiply / multiply-accumulate: one multiplier and one
// adder stepped through four partial products, with sticky signed overflow.
module cmac_seq
  import cmac_pkg::*;
#(
  parameter int CW    = 8,
  parameter int GUARD = 2,
  localparam int OW   = ow_width(CW, GUARD)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            conj_b,
  input  logic            acc,
  input  logic [2*CW-1:0] a,
  input  logic [2*CW-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [2*OW-1:0] y,
  output logic            ovf
);

  cmac_state_e r_state, w_state_next;

  logic signed [CW-1:0]   r_ar, r_ai, r_br, r_bi;
  logic                   r_conj;
  logic signed [OW-1:0]   r_tr, r_ti;
  logic [1:0][OW-1:0]     r_y;
  logic                   r_ovf;

  logic [1:0][CW-1:0]     w_a, w_b;
  logic signed [CW-1:0]   w_mul_a, w_mul_b;
  logic signed [2*CW-1:0] w_prod;
  logic signed [OW-1:0]   w_prod_ext, w_addend, w_lhs, w_sum;
  logic                   w_sub, w_add_ovf, w_accept, w_compute;

  assign w_a = a;
  assign w_b = b;

  assign w_accept  = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_compute = (r_state == ST_M0) || (r_state == ST_M1) ||
                     (r_state == ST_M2) || (r_state == ST_M3);

  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    unique case (r_state)
      ST_M0:   begin w_mul_a = r_ar; w_mul_b = r_br; end
      ST_M1:   begin w_mul_a = r_ai; w_mul_b = r_bi; end
      ST_M2:   begin w_mul_a = r_ar; w_mul_b = r_bi; end
      ST_M3:   begin w_mul_a = r_ai; w_mul_b = r_br; end
      default: begin w_mul_a = '0;   w_mul_b = '0;   end
    endcase
  end

  cmac_smul #(.CW(CW)) u_smul (
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_prod)
  );

  // Negating the sign-extended product cannot overflow: it has GUARD spare bits.
  assign w_prod_ext = OW'(w_prod);
  assign w_sub      = ((r_state == ST_M1) && !r_conj) || ((r_state == ST_M2) && r_conj);
  assign w_addend   = w_sub ? -w_prod_ext : w_prod_ext;
  assign w_lhs      = ((r_state == ST_M0) || (r_state == ST_M1)) ? r_tr : r_ti;
  assign w_sum      = w_lhs + w_addend;
  assign w_add_ovf  = (w_lhs[OW-1] == w_addend[OW-1]) && (w_sum[OW-1] != w_lhs[OW-1]);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (start) w_state_next = ST_M0;
      ST_M0:   w_state_next = ST_M1;
      ST_M1:   w_state_next = ST_M2;
      ST_M2:   w_state_next = ST_M3;
      ST_M3:   w_state_next = ST_DONE;
      ST_DONE: w_state_next = start ? ST_M0 : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ar    <= '0;
      r_ai    <= '0;
      r_br    <= '0;
      r_bi    <= '0;
      r_conj  <= 1'b0;
      r_tr    <= '0;
      r_ti    <= '0;
      r_y     <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_ar   <= w_a[FLD_RE];
        r_ai   <= w_a[FLD_IM];
        r_br   <= w_b[FLD_RE];
        r_bi   <= w_b[FLD_IM];
        r_conj <= conj_b;
        r_tr   <= acc ? r_y[FLD_RE] : '0;
        r_ti   <= acc ? r_y[FLD_IM] : '0;
        if (!acc) r_ovf <= 1'b0;
      end else if (w_compute) begin
        if (w_add_ovf) r_ovf <= 1'b1;
        if (r_state == ST_M0 || r_state == ST_M1) begin
          r_tr <= w_sum;
        end else begin
          r_ti <= w_sum;
        end
        if (r_state == ST_M3) begin
          r_y[FLD_RE] <= r_tr;
          r_y[FLD_IM] <= w_sum;
        end
      end
    end
  end

  assign busy = w_compute;
  assign done = (r_state == ST_DONE);
  assign y    = r_y;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_cmac_seq.sv
// Directed bench for cmac_seq with hand-computed complex products (CW=8, GUARD=2).
module tb_cmac_seq;

  localparam int CW = 8;
  localparam int OW = 18;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            conj_b = 1'b0;
  logic            acc = 1'b0;
  logic [2*CW-1:0] a = '0;
  logic [2*CW-1:0] b = '0;
  logic            busy, done, ovf;
  logic [2*OW-1:0] y;

  int n_vec = 0;
  int n_bad = 0;

  cmac_seq #(.CW(CW), .GUARD(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .conj_b (conj_b),
    .acc    (acc),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .y      (y),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  function automatic logic [2*CW-1:0] pack(input int re, input int im);
    logic [31:0] r, i;
    r = re;
    i = im;
    return {r[CW-1:0], i[CW-1:0]};
  endfunction

  function automatic longint y_re();
    logic signed [OW-1:0] v;
    v = y[2*OW-1:OW];
    return longint'(v);
  endfunction

  function automatic longint y_im();
    logic signed [OW-1:0] v;
    v = y[OW-1:0];
    return longint'(v);
  endfunction

  // Issue one operation and check latency, busy duration, result and ovf.
  task automatic do_op(input string tag, input int ar, ai, br, bi,
                       input bit cj, ac, input int exp_re, exp_im, input bit exp_ovf);
    int cyc;
    int busy_cnt;
    @(negedge clk);
    a = pack(ar, ai); b = pack(br, bi); conj_b = cj; acc = ac; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = pack(-1, -1); b = pack(-1, -1); conj_b = ~cj; acc = ~ac;
    cyc = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
      if (busy) busy_cnt++;
    end
    chk({tag, ".latency"}, cyc, 4);
    chk({tag, ".busy_cycles"}, busy_cnt, 4);
    chk({tag, ".re"}, y_re(), exp_re);
    chk({tag, ".im"}, y_im(), exp_im);
    chk({tag, ".ovf"}, ovf, exp_ovf);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, done, 0);
  endtask

  initial begin
    int cyc;
    int done_cnt;
    int d_at [4];
    longint keep_re, keep_im;

    #2;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.y", y, 0);
    chk("rst.ovf", ovf, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    do_op("mul",    3, 4, 2, 5, 0, 0, -14, 23, 0);
    do_op("conj",   3, 4, 2, 5, 1, 0,  26, -7, 0);
    do_op("acc0",   1, 1, 1, 1, 0, 0,   0,  2, 0);
    do_op("acc1",   2, 0, 3, 0, 0, 1,   6,  2, 0);
    do_op("m128",  -128, -128, -128, -128, 0, 0, 0,  32768, 0);
    do_op("m128a1", -128, -128, -128, -128, 0, 1, 0,  65536, 0);
    do_op("m128a2", -128, -128, -128, -128, 0, 1, 0,  98304, 0);
    do_op("m128a3", -128, -128, -128, -128, 0, 1, 0, -131072, 1);
    do_op("ovfclr", 1, 0, 1, 0, 0, 0, 1, 0, 0);

    // start pulsed during M1 with other operands must be ignored
    @(negedge clk);
    a = pack(3, 4); b = pack(2, 5); conj_b = 0; acc = 0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    a = pack(7, 7); b = pack(7, 7); conj_b = 1; acc = 1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 2;
    while (!done && cyc < 10) begin
      @(posedge clk); #1; cyc++;
    end
    chk("ign.latency", cyc, 4);
    chk("ign.re", y_re(), -14);
    chk("ign.im", y_im(), 23);
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    chk("ign.extra_done", done_cnt, 0);
    chk("ign.busy_after", busy, 0);

    // reset in M2 aborts immediately
    @(negedge clk);
    a = pack(1, 2); b = pack(3, 4); conj_b = 0; acc = 0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("abort.busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk("abort.y", y, 0);
    chk("abort.ovf", ovf, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    do_op("post", 1, 2, 3, 4, 0, 0, -5, 10, 0);

    // start held high: one result every 5 cycles
    @(negedge clk);
    a = pack(3, 4); b = pack(2, 5); conj_b = 1; acc = 0; start = 1'b1;
    for (int k = 0; k < 4; k++) d_at[k] = -1;
    done_cnt = 0;
    for (int c = 0; c < 22; c++) begin
      @(posedge clk); #1;
      if (done && done_cnt < 4) begin
        d_at[done_cnt] = c;
        done_cnt++;
      end
    end
    start = 1'b0;
    chk("b2b.first", d_at[0], 4);
    chk("b2b.gap1", d_at[1] - d_at[0], 5);
    chk("b2b.gap2", d_at[2] - d_at[1], 5);
    keep_re = y_re();
    keep_im = y_im();
    chk("b2b.re", keep_re, 26);
    chk("b2b.im", keep_im, -7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
